// File: rtl/cpu_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : arbiter FSM state (idle / waiting for response)
//   arb_owner_e : which requester owns the outstanding transaction
//   mem_req_t   : one memory access (write flag, address, write data, byte enables)
package cpu_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/arb_lat_counter.sv
// Response latency counter for the memory port arbiter.
//   clk, reset : clock, asynchronous active-high reset
//   load       : transaction granted, restart the count at MEM_LAT
//   dec        : a transaction is outstanding, count down one
//   done       : count is 1, i.e. this is the response cycle
module arb_lat_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CW'(MEM_LAT);
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and the
// load/store unit (LS). One transaction outstanding, fixed read latency.
// LS wins by default; after STARVE_MAX consecutive lost slots IF is forced in.
//   clk, reset                  : clock, asynchronous active-high reset
//   if_req/if_addr              : fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata   : fetch grant, response pulse, response data
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_be              : load/store request (held until ls_gnt)
//   ls_gnt/ls_rvalid/ls_rdata   : LS grant, response pulse, load data (0 on store ack)
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_be            : memory access, driven in the grant cycle
//   mem_rdata                   : memory read data, valid MEM_LAT cycles after mem_en
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic          store_q, store_d;
  logic [SW-1:0] starve_q, starve_d;

  logic     lat_done, resp, slot, if_starved, ls_win, if_win, grant;
  mem_req_t mreq;

  arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk  (clk),
    .reset(reset),
    .load (grant),
    .dec  (state_q == ARB_BUSY),
    .done (lat_done)
  );

  always_comb begin
    resp       = (state_q == ARB_BUSY) && lat_done;
    // a new grant may overlap the response cycle of the previous one
    slot       = (state_q == ARB_IDLE) || resp;
    if_starved = if_req && (starve_q == SW'(STARVE_MAX));
    // grants are combinational with req, so mask them while reset is held
    ls_win     = !reset && slot && ls_req && !if_starved;
    if_win     = !reset && slot && if_req && !ls_win;
    grant      = ls_win || if_win;

    mreq = '0;
    if (ls_win) begin
      mreq = '{we: ls_we, addr: ls_addr, wdata: ls_wdata, be: ls_be};
    end else if (if_win) begin
      mreq.addr = if_addr;
      mreq.be   = '1;
    end

    state_d  = state_q;
    owner_d  = owner_q;
    store_d  = store_q;
    starve_d = starve_q;
    if (slot)
      state_d = grant ? ARB_BUSY : ARB_IDLE;
    if (ls_win) begin
      owner_d = OWN_LS;
      store_d = ls_we;
      if (if_req && starve_q != SW'(STARVE_MAX))
        starve_d = starve_q + SW'(1);
    end
    if (if_win) begin
      owner_d  = OWN_IF;
      store_d  = 1'b0;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      store_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      store_q  <= store_d;
      starve_q <= starve_d;
    end
  end

  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign mem_en    = grant;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;
  assign mem_be    = mreq.be;

  assign if_rvalid = resp && (owner_q == OWN_IF);
  assign ls_rvalid = resp && (owner_q == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  // a store ack carries no data
  assign ls_rdata  = (ls_rvalid && !store_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32, DW = 32, BW = 4, SMAX = 3;

  typedef struct packed {
    bit          if_gnt, ls_gnt, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    bit          if_rv;
    logic [31:0] if_rd;
    bit          ls_rv;
    logic [31:0] ls_rd;
  } outs_t;

  typedef struct packed {
    bit          rst, if_req;
    logic [31:0] if_addr;
    bit          ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic [31:0] mem_rdata;
  } ins_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  logic          if_req[2], ls_req[2], ls_we[2];
  logic [AW-1:0] if_addr[2], ls_addr[2];
  logic [DW-1:0] ls_wdata[2], mem_rdata[2];
  logic [BW-1:0] ls_be[2];
  logic          if_gnt[2], if_rvalid[2], ls_gnt[2], ls_rvalid[2], mem_en[2], mem_we[2];
  logic [DW-1:0] if_rdata[2], ls_rdata[2], mem_wdata[2];
  logic [AW-1:0] mem_addr[2];
  logic [BW-1:0] mem_be[2];

  always #5 clk = ~clk;

  // instance 0: MEM_LAT=1, instance 1: MEM_LAT=3
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g == 0 ? 1 : 3), .STARVE_MAX(SMAX)
    ) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_addr(ls_addr[g]),
      .ls_wdata(ls_wdata[g]), .ls_be(ls_be[g]), .ls_gnt(ls_gnt[g]),
      .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]), .mem_rdata(mem_rdata[g])
    );
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic outs_t get_act(int k);
    outs_t a;
    a.if_gnt = if_gnt[k];   a.ls_gnt = ls_gnt[k];
    a.mem_en = mem_en[k];   a.mem_we = mem_we[k];
    a.mem_addr = mem_addr[k]; a.mem_wdata = mem_wdata[k]; a.mem_be = mem_be[k];
    a.if_rv = if_rvalid[k]; a.if_rd = if_rdata[k];
    a.ls_rv = ls_rvalid[k]; a.ls_rd = ls_rdata[k];
    return a;
  endfunction

  task automatic cmp_outs(input string tag, input outs_t a, input outs_t e);
    chk({tag, ".if_gnt"},    64'(a.if_gnt),    64'(e.if_gnt));
    chk({tag, ".ls_gnt"},    64'(a.ls_gnt),    64'(e.ls_gnt));
    chk({tag, ".mem_en"},    64'(a.mem_en),    64'(e.mem_en));
    chk({tag, ".mem_we"},    64'(a.mem_we),    64'(e.mem_we));
    chk({tag, ".mem_addr"},  64'(a.mem_addr),  64'(e.mem_addr));
    chk({tag, ".mem_wdata"}, 64'(a.mem_wdata), 64'(e.mem_wdata));
    chk({tag, ".mem_be"},    64'(a.mem_be),    64'(e.mem_be));
    chk({tag, ".if_rvalid"}, 64'(a.if_rv),     64'(e.if_rv));
    chk({tag, ".if_rdata"},  64'(a.if_rd),     64'(e.if_rd));
    chk({tag, ".ls_rvalid"}, 64'(a.ls_rv),     64'(e.ls_rv));
    chk({tag, ".ls_rdata"},  64'(a.ls_rd),     64'(e.ls_rd));
  endtask

  // ---------------- reference model (transaction level) ----------------
  // The outstanding transaction is remembered as the absolute cycle number
  // at which its response is due.
  int cyc = 0;
  bit m_pend[2], m_ls[2], m_store[2], m_lw[2], m_iw[2];
  int m_due[2], m_starve[2];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void predict(int k, output outs_t e, output bit lw, output bit iw);
    bit resp, slot;
    e = '0; lw = 1'b0; iw = 1'b0;
    if (reset) return;
    resp = m_pend[k] && (m_due[k] == cyc);
    slot = !m_pend[k] || resp;
    if (slot) begin
      if (ls_req[k] && !(if_req[k] && m_starve[k] >= SMAX)) lw = 1'b1;
      else if (if_req[k])                                   iw = 1'b1;
    end
    e.if_gnt = iw;
    e.ls_gnt = lw;
    e.mem_en = lw | iw;
    if (lw) begin
      e.mem_we = ls_we[k]; e.mem_addr = ls_addr[k];
      e.mem_wdata = ls_wdata[k]; e.mem_be = ls_be[k];
    end else if (iw) begin
      e.mem_addr = if_addr[k]; e.mem_be = 4'hF;
    end
    e.if_rv = resp && !m_ls[k];
    e.if_rd = e.if_rv ? mem_rdata[k] : 32'h0;
    e.ls_rv = resp && m_ls[k];
    e.ls_rd = (e.ls_rv && !m_store[k]) ? mem_rdata[k] : 32'h0;
  endfunction

  // Call at the negedge: check both instances against the model, then
  // cross the rising edge, advance the model and step 1 time unit past it.
  task automatic adv();
    outs_t e;
    for (int k = 0; k < 2; k++) begin
      predict(k, e, m_lw[k], m_iw[k]);
      cmp_outs($sformatf("model%0d@%0d", k, cyc), get_act(k), e);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pend[k] = 1'b0; m_starve[k] = 0;
        m_lw[k] = 1'b0; m_iw[k] = 1'b0;
      end else begin
        if (m_pend[k] && m_due[k] == cyc) m_pend[k] = 1'b0;
        if (m_lw[k] || m_iw[k]) begin
          m_pend[k] = 1'b1; m_due[k] = cyc + lat_of(k);
          m_ls[k] = m_lw[k]; m_store[k] = m_lw[k] && ls_we[k];
        end
        if (m_lw[k] && if_req[k] && m_starve[k] < SMAX) m_starve[k]++;
        if (m_iw[k]) m_starve[k] = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(int k, ins_t v);
    if_req[k] = v.if_req;  if_addr[k] = v.if_addr;
    ls_req[k] = v.ls_req;  ls_we[k] = v.ls_we;   ls_addr[k] = v.ls_addr;
    ls_wdata[k] = v.ls_wdata; ls_be[k] = v.ls_be; mem_rdata[k] = v.mem_rdata;
  endtask

  function automatic ins_t vi(bit rst, bit ir, logic [31:0] ia, bit lr, bit we,
                              logic [31:0] la, logic [31:0] wd, logic [3:0] be,
                              logic [31:0] rd);
    return '{rst, ir, ia, lr, we, la, wd, be, rd};
  endfunction

  function automatic outs_t vo(bit ig, bit lg, bit en, bit we, logic [31:0] ad,
                               logic [31:0] wd, logic [3:0] be, bit irv,
                               logic [31:0] ird, bit lrv, logic [31:0] lrd);
    return '{ig, lg, en, we, ad, wd, be, irv, ird, lrv, lrd};
  endfunction

  // random stimulus obeying the hold-until-grant rule (drops allowed)
  task automatic drive_rand(int k);
    if (!if_req[k] || m_iw[k]) begin
      if_req[k]  = ($urandom_range(0, 1) == 1);
      if_addr[k] = $urandom & 32'hFFFF_FFFC;
    end else if ($urandom_range(0, 7) == 0) begin
      if_req[k] = 1'b0;
    end
    if (!ls_req[k] || m_lw[k]) begin
      ls_req[k]   = ($urandom_range(0, 3) != 0);
      ls_we[k]    = ($urandom_range(0, 1) == 1);
      ls_addr[k]  = $urandom;
      ls_wdata[k] = $urandom;
      ls_be[k]    = 4'($urandom);
    end else if ($urandom_range(0, 7) == 0) begin
      ls_req[k] = 1'b0;
    end
    mem_rdata[k] = $urandom;
  endtask

  vec_t tbl[15];
  ins_t idle_in;

  initial begin
    idle_in = vi(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // MEM_LAT=1 instance: reset, IF read, simultaneous requests, starvation, store
    tbl[0]  = '{vi(1,1,32'h4,0,0,0,0,0,0),              vo(0,0,0,0,0,0,0,0,0,0,0)};
    tbl[1]  = '{vi(1,1,32'h4,0,0,0,0,0,0),              vo(0,0,0,0,0,0,0,0,0,0,0)};
    tbl[2]  = '{vi(0,1,32'h4,0,0,0,0,0,0),              vo(1,0,1,0,32'h4,0,4'hF,0,0,0,0)};
    tbl[3]  = '{vi(0,0,32'h4,0,0,0,0,0,32'h00208033),   vo(0,0,0,0,0,0,0,1,32'h00208033,0,0)};
    tbl[4]  = '{vi(0,1,32'h10,1,0,32'h0,0,4'hF,0),      vo(0,1,1,0,32'h0,0,4'hF,0,0,0,0)};
    tbl[5]  = '{vi(0,1,32'h10,0,0,0,0,4'hF,32'h11111111), vo(1,0,1,0,32'h10,0,4'hF,0,0,1,32'h11111111)};
    tbl[6]  = '{vi(0,0,32'h10,0,0,0,0,4'hF,32'h22222222), vo(0,0,0,0,0,0,0,1,32'h22222222,0,0)};
    tbl[7]  = '{vi(0,1,32'h30,1,0,32'h20,0,4'hF,0),     vo(0,1,1,0,32'h20,0,4'hF,0,0,0,0)};
    tbl[8]  = '{vi(0,1,32'h30,1,0,32'h20,0,4'hF,32'h33), vo(0,1,1,0,32'h20,0,4'hF,0,0,1,32'h33)};
    tbl[9]  = '{vi(0,1,32'h30,1,0,32'h20,0,4'hF,32'h44), vo(0,1,1,0,32'h20,0,4'hF,0,0,1,32'h44)};
    tbl[10] = '{vi(0,1,32'h30,1,0,32'h20,0,4'hF,32'h55), vo(1,0,1,0,32'h30,0,4'hF,0,0,1,32'h55)};
    tbl[11] = '{vi(0,0,32'h30,1,0,32'h20,0,4'hF,32'h66), vo(0,1,1,0,32'h20,0,4'hF,1,32'h66,0,0)};
    tbl[12] = '{vi(0,0,0,0,0,0,0,0,32'h77),             vo(0,0,0,0,0,0,0,0,0,1,32'h77)};
    tbl[13] = '{vi(0,0,0,1,1,32'h8,32'hDEADBEEF,4'hF,0), vo(0,1,1,1,32'h8,32'hDEADBEEF,4'hF,0,0,0,0)};
    tbl[14] = '{vi(0,0,0,0,0,0,0,0,32'h12345678),       vo(0,0,0,0,0,0,0,0,0,1,32'h0)};

    reset = 1'b1;
    drive(1, idle_in);
    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].in.rst;
      drive(0, tbl[i].in);
      @(negedge clk);
      cmp_outs($sformatf("vec%0d", i), get_act(0), tbl[i].exp);
      adv();
    end

    // MEM_LAT=3: reset one cycle after a grant discards the response
    drive(0, idle_in);
    if_req[1] = 1'b1; if_addr[1] = 32'h40;
    @(negedge clk);
    chk("t6.if_gnt", 64'(if_gnt[1]), 64'd1);
    adv();
    if_req[1] = 1'b0; reset = 1'b1;
    @(negedge clk);
    cmp_outs("t6.in_reset", get_act(1), '0);
    adv();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t6.no_if_rvalid%0d", i), 64'(if_rvalid[1]), 64'd0);
      chk($sformatf("t6.no_ls_rvalid%0d", i), 64'(ls_rvalid[1]), 64'd0);
      adv();
    end
    // next request granted normally; an IF request in the busy window waits
    ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h50; ls_be[1] = 4'hF;
    @(negedge clk);
    chk("t6.ls_gnt", 64'(ls_gnt[1]), 64'd1);
    chk("t6.mem_addr", 64'(mem_addr[1]), 64'h50);
    adv();
    ls_req[1] = 1'b0; if_req[1] = 1'b1; if_addr[1] = 32'h60; mem_rdata[1] = 32'hCAFEF00D;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6.ls_rvalid+%0d", i), 64'(ls_rvalid[1]), 64'(i == 3));
      chk($sformatf("t6.if_gnt_wait+%0d", i), 64'(if_gnt[1]), 64'(i == 3));
      if (i == 3) chk("t6.ls_rdata", 64'(ls_rdata[1]), 64'hCAFEF00D);
      adv();
    end
    if_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      adv();
    end

    // randomized traffic on both instances, checked against the model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) drive_rand(k);
      @(negedge clk);
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
